// File: rtl/k12a_sequencer.sv
// K12a registered state sequencer: owns the state register, inserts memory wait states with a
// registered write strobe, and arbitrates edge-triggered interrupts at FETCH1/HALT boundaries.

package k12a_pkg;
  typedef enum logic [2:0] {
    STATE_FETCH1 = 3'd0,
    STATE_FETCH2 = 3'd1,
    STATE_FETCH3 = 3'd2,
    STATE_EXEC   = 3'd3,
    STATE_HALT   = 3'd4,
    STATE_IRQ    = 3'd5
  } state_t;
endpackage

module k12a_sequencer
  import k12a_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned IRQ_COUNT   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  state_t               state_next_req,
  input  logic                 mem_enable,
  input  logic                 mem_write,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic                 irq_enable,
  output state_t               state,
  output logic                 advance,
  output logic                 async_write,
  output logic                 irq_taken,
  output logic [2:0]           irq_vector,
  output logic [IRQ_COUNT-1:0] irq_pending
);

  if (WAIT_STATES < 2 || WAIT_STATES > 15) begin : gen_bad_wait_states
    $error("k12a_sequencer: WAIT_STATES must be in 2..15");
  end
  if (IRQ_COUNT < 1 || IRQ_COUNT > 8) begin : gen_bad_irq_count
    $error("k12a_sequencer: IRQ_COUNT must be in 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : gen_bad_sync_stages
    $error("k12a_sequencer: SYNC_STAGES must be in 2..3");
  end

  localparam logic [3:0] WaitMax  = 4'(WAIT_STATES);
  localparam logic [3:0] WaitLast = 4'(WAIT_STATES - 1);

  state_t               state_q, state_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 async_write_q, async_write_d;
  logic [2:0]           irq_vector_q, irq_vector_d;
  logic [IRQ_COUNT-1:0] irq_pending_q, irq_pending_d;
  logic [IRQ_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_COUNT-1:0] sync_d [SYNC_STAGES];
  logic [IRQ_COUNT-1:0] edge_q;
  logic [IRQ_COUNT-1:0] irq_rise;
  logic [IRQ_COUNT-1:0] take_mask;
  logic [2:0]           take_index;
  logic                 take_irq;
  state_t               state_sel;

  assign advance  = ~mem_enable | (wait_cnt_q == WaitMax);
  assign irq_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_comb begin
    sync_d[0] = irq;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Lowest-index pending line wins; descending scan lets the last match overwrite.
  always_comb begin
    take_index = 3'd0;
    take_mask  = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (irq_pending_q[i]) begin
        take_index   = 3'(i);
        take_mask    = '0;
        take_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_sel = state_next_req;
    if (state_q == STATE_IRQ) begin
      state_sel = STATE_FETCH1;
    end else if (state_q == STATE_HALT && irq_pending_q != '0) begin
      state_sel = irq_enable ? STATE_IRQ : STATE_FETCH1;
    end else if (state_next_req == STATE_FETCH1 && irq_enable && irq_pending_q != '0) begin
      state_sel = STATE_IRQ;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    async_write_d = async_write_q;
    irq_vector_d  = irq_vector_q;
    take_irq      = 1'b0;

    if (advance) begin
      state_d    = state_sel;
      wait_cnt_d = 4'd0;
      take_irq   = (state_sel == STATE_IRQ) && (state_q != STATE_IRQ);
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Strobe spans wait_cnt 1..WAIT_STATES-1, leaving one cycle of setup and one of hold.
    if (mem_enable && mem_write && wait_cnt_q == 4'd0) begin
      async_write_d = 1'b1;
    end else if (!mem_enable || wait_cnt_q >= WaitLast) begin
      async_write_d = 1'b0;
    end

    irq_pending_d = irq_pending_q | irq_rise;
    if (take_irq) begin
      irq_vector_d  = take_index;
      irq_pending_d = (irq_pending_q & ~take_mask) | irq_rise;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= STATE_FETCH1;
      wait_cnt_q    <= 4'd0;
      async_write_q <= 1'b0;
      irq_vector_q  <= 3'd0;
      irq_pending_q <= '0;
      edge_q        <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      async_write_q <= async_write_d;
      irq_vector_q  <= irq_vector_d;
      irq_pending_q <= irq_pending_d;
      edge_q        <= sync_q[SYNC_STAGES-1];
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign state       = state_q;
  assign async_write = async_write_q;
  assign irq_taken   = (state_q == STATE_IRQ);
  assign irq_vector  = irq_vector_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_k12a_sequencer.sv
// Directed bench for k12a_sequencer: wait states, write strobe, reset, interrupt arbitration.

module tb_k12a_sequencer;
  import k12a_pkg::*;

  logic       clock;
  logic       reset_n;
  state_t     state_next_req;
  logic       mem_enable;
  logic       mem_write;
  logic [3:0] irq;
  logic       irq_enable;
  state_t     state;
  logic       advance;
  logic       async_write;
  logic       irq_taken;
  logic [2:0] irq_vector;
  logic [3:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;

  k12a_sequencer #(
    .WAIT_STATES(3),
    .IRQ_COUNT  (4),
    .SYNC_STAGES(2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .state_next_req(state_next_req),
    .mem_enable    (mem_enable),
    .mem_write     (mem_write),
    .irq           (irq),
    .irq_enable    (irq_enable),
    .state         (state),
    .advance       (advance),
    .async_write   (async_write),
    .irq_taken     (irq_taken),
    .irq_vector    (irq_vector),
    .irq_pending   (irq_pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    state_next_req = STATE_FETCH1;
    mem_enable     = 1'b0;
    mem_write      = 1'b0;
    irq            = 4'b0000;
    irq_enable     = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'(STATE_FETCH1));
    check("rst_async_write", 32'(async_write), 0);
    check("rst_pending", 32'(irq_pending), 0);
    check("rst_vector", 32'(irq_vector), 0);
    check("rst_irq_taken", 32'(irq_taken), 0);
    reset_n = 1'b1;
    tick();

    // Write access, WAIT_STATES=3: four cycles, strobe in cycles 2-3.
    state_next_req = STATE_FETCH2;
    mem_enable     = 1'b1;
    mem_write      = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wr_c%0d_state", c), 32'(state), 32'(STATE_FETCH1));
      check($sformatf("wr_c%0d_async", c), 32'(async_write), (c == 2 || c == 3) ? 1 : 0);
      check($sformatf("wr_c%0d_advance", c), 32'(advance), (c == 4) ? 1 : 0);
      tick();
    end
    check("wr_done_state", 32'(state), 32'(STATE_FETCH2));

    // Read access: strobe never high.
    state_next_req = STATE_FETCH3;
    mem_write      = 1'b0;
    #1;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("rd_c%0d_async", c), 32'(async_write), 0);
      check($sformatf("rd_c%0d_advance", c), 32'(advance), (c == 4) ? 1 : 0);
      tick();
    end
    check("rd_done_state", 32'(state), 32'(STATE_FETCH3));

    // Non-memory states advance every cycle.
    mem_enable     = 1'b0;
    state_next_req = STATE_EXEC;
    #1;
    check("nm_advance", 32'(advance), 1);
    tick();
    check("nm_exec", 32'(state), 32'(STATE_EXEC));
    state_next_req = STATE_EXEC;
    tick();
    check("nm_exec_hold", 32'(state), 32'(STATE_EXEC));

    // Reset asserted mid-write from EXEC.
    state_next_req = STATE_FETCH1;
    mem_enable     = 1'b1;
    mem_write      = 1'b1;
    tick();
    check("mw_async", 32'(async_write), 1);
    check("mw_state", 32'(state), 32'(STATE_EXEC));
    #2;
    reset_n = 1'b0;
    #1;
    check("mw_rst_async", 32'(async_write), 0);
    check("mw_rst_state", 32'(state), 32'(STATE_FETCH1));
    #2;
    mem_enable     = 1'b0;
    mem_write      = 1'b0;
    state_next_req = STATE_FETCH1;
    reset_n        = 1'b1;
    tick();
    check("mw_post_state", 32'(state), 32'(STATE_FETCH1));
    check("mw_post_advance", 32'(advance), 1);

    // Priority: lines 1 and 3 rise together.
    state_next_req = STATE_EXEC;
    irq            = 4'b1010;
    tick();
    tick();
    check("pr_latency_pending", 32'(irq_pending), 0);
    tick();
    check("pr_pending", 32'(irq_pending), 32'h0a);
    check("pr_no_take", 32'(state), 32'(STATE_EXEC));
    irq            = 4'b0000;
    state_next_req = STATE_FETCH1;
    irq_enable     = 1'b1;
    tick();
    check("pr1_state", 32'(state), 32'(STATE_IRQ));
    check("pr1_taken", 32'(irq_taken), 1);
    check("pr1_vector", 32'(irq_vector), 1);
    check("pr1_pending", 32'(irq_pending), 32'h08);
    state_next_req = STATE_EXEC;
    tick();
    check("pr1_exit", 32'(state), 32'(STATE_FETCH1));
    check("pr1_taken_low", 32'(irq_taken), 0);
    state_next_req = STATE_FETCH1;
    tick();
    check("pr2_state", 32'(state), 32'(STATE_IRQ));
    check("pr2_vector", 32'(irq_vector), 3);
    check("pr2_pending", 32'(irq_pending), 0);
    state_next_req = STATE_EXEC;
    tick();
    check("pr2_exit", 32'(state), 32'(STATE_FETCH1));
    check("pr2_vector_held", 32'(irq_vector), 3);

    // Halt wake with interrupts disabled, then repeated halt with them enabled.
    irq_enable     = 1'b0;
    state_next_req = STATE_HALT;
    tick();
    check("hw_halt", 32'(state), 32'(STATE_HALT));
    irq = 4'b0100;
    tick();
    irq = 4'b0000;
    tick();
    tick();
    check("hw_pending", 32'(irq_pending), 32'h04);
    check("hw_still_halt", 32'(state), 32'(STATE_HALT));
    tick();
    check("hw_wake", 32'(state), 32'(STATE_FETCH1));
    check("hw_pending_kept", 32'(irq_pending), 32'h04);
    tick();
    check("hw_rehalt", 32'(state), 32'(STATE_HALT));
    irq_enable = 1'b1;
    tick();
    check("hw_irq_state", 32'(state), 32'(STATE_IRQ));
    check("hw_irq_vector", 32'(irq_vector), 2);
    check("hw_irq_pending", 32'(irq_pending), 0);
    tick();
    check("hw_irq_exit", 32'(state), 32'(STATE_FETCH1));

    // Set/clear collision on line 0.
    irq_enable     = 1'b0;
    state_next_req = STATE_EXEC;
    irq            = 4'b0001;
    tick();
    irq = 4'b0000;
    tick();
    tick();
    check("co_pending", 32'(irq_pending), 32'h01);
    irq = 4'b0001;
    tick();
    tick();
    state_next_req = STATE_FETCH1;
    irq_enable     = 1'b1;
    tick();
    check("co_state", 32'(state), 32'(STATE_IRQ));
    check("co_taken", 32'(irq_taken), 1);
    check("co_vector", 32'(irq_vector), 0);
    check("co_pending_kept", 32'(irq_pending), 32'h01);
    state_next_req = STATE_EXEC;
    tick();
    check("co_exit", 32'(state), 32'(STATE_FETCH1));
    tick();
    check("co_level_no_rearm", 32'(irq_pending), 32'h01);
    check("co_exec", 32'(state), 32'(STATE_EXEC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
